// File: rtl/types_pkg.sv
// Shared ROB constants and the writeback/entry records used by the core pipeline.
package types_pkg;

  localparam int unsigned ROB_DEPTH = 32;
  localparam int unsigned TAG_W     = 5;
  localparam int unsigned PREG_W    = 7;

  typedef logic [TAG_W-1:0]  rob_tag_t;
  typedef logic [PREG_W-1:0] preg_t;

  typedef struct packed {
    preg_t       pd_new;
    preg_t       pd_old;
    logic [31:0] pc;
    logic        complete;
    rob_tag_t    rob_index;
    logic        valid;
  } rob_data;

  typedef struct packed {
    logic     fu_alu_done;
    rob_tag_t rob_fu_alu;
  } alu_data;

  typedef struct packed {
    logic     fu_mem_done;
    rob_tag_t rob_fu_mem;
  } mem_data;

  typedef struct packed {
    logic     fu_b_done;
    logic     mispredict;
    rob_tag_t mispredict_tag;
  } b_data;

  // Distance of an index from the head, modulo the ring size.
  function automatic rob_tag_t rob_age(input rob_tag_t idx, input rob_tag_t head);
    return idx - head;
  endfunction

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates at tail, collects up to three completions per cycle,
// retires one completed head entry per cycle and squashes younger entries on a mispredict.
module reorder_buffer #(
  parameter int unsigned ROB_DEPTH = types_pkg::ROB_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alloc_valid,
  input  types_pkg::preg_t         alloc_pd_new,
  input  types_pkg::preg_t         alloc_pd_old,
  input  logic [31:0]              alloc_pc,
  output logic                     alloc_ready,
  output types_pkg::rob_tag_t      alloc_tag,
  input  types_pkg::alu_data       alu_wb,
  input  types_pkg::mem_data       mem_wb,
  input  types_pkg::b_data         b_wb,
  input  types_pkg::rob_tag_t      b_rob_tag,
  output logic                     commit_valid,
  output types_pkg::preg_t         commit_pd_old,
  output types_pkg::preg_t         commit_pd_new,
  output logic [31:0]              commit_pc,
  output types_pkg::rob_tag_t      commit_tag,
  output logic                     rob_full,
  output logic                     rob_empty,
  output logic [5:0]               rob_count
);

  types_pkg::rob_data  entries_q [ROB_DEPTH];
  types_pkg::rob_data  entries_d [ROB_DEPTH];
  types_pkg::rob_tag_t head_q, head_d;
  types_pkg::rob_tag_t tail_q, tail_d;
  logic [5:0]          count_q, count_d;

  logic                mispredict;
  logic                alloc_fire;
  types_pkg::rob_tag_t br_age;
  types_pkg::rob_data  head_entry;

  assign head_entry = entries_q[head_q];
  assign mispredict = b_wb.fu_b_done & b_wb.mispredict;
  assign br_age     = types_pkg::rob_age(b_wb.mispredict_tag, head_q);
  assign alloc_fire = alloc_valid & alloc_ready;

  always_comb begin
    alloc_ready   = (count_q < 6'(ROB_DEPTH)) && !mispredict;
    alloc_tag     = tail_q;
    commit_valid  = head_entry.valid & head_entry.complete;
    commit_pd_old = head_entry.pd_old;
    commit_pd_new = head_entry.pd_new;
    commit_pc     = head_entry.pc;
    commit_tag    = head_q;
    rob_full      = (count_q == 6'(ROB_DEPTH));
    rob_empty     = (count_q == 6'd0);
    rob_count     = count_q;
  end

  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;

    // Completions only land on live entries; a same-cycle squash below overrides them.
    if (alu_wb.fu_alu_done && entries_q[alu_wb.rob_fu_alu].valid) begin
      entries_d[alu_wb.rob_fu_alu].complete = 1'b1;
    end
    if (mem_wb.fu_mem_done && entries_q[mem_wb.rob_fu_mem].valid) begin
      entries_d[mem_wb.rob_fu_mem].complete = 1'b1;
    end
    if (b_wb.fu_b_done && entries_q[b_rob_tag].valid) begin
      entries_d[b_rob_tag].complete = 1'b1;
    end

    if (mispredict) begin
      for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
        if (types_pkg::rob_age(types_pkg::rob_tag_t'(i), head_q) > br_age) begin
          entries_d[i].valid    = 1'b0;
          entries_d[i].complete = 1'b0;
        end
      end
      if (entries_q[b_wb.mispredict_tag].valid) begin
        entries_d[b_wb.mispredict_tag].complete = 1'b1;
      end
      tail_d  = b_wb.mispredict_tag + 1'b1;
      count_d = 6'(br_age) + 6'd1 - 6'(commit_valid);
    end else begin
      count_d = count_q + 6'(alloc_fire) - 6'(commit_valid);
    end

    if (commit_valid) begin
      entries_d[head_q].valid    = 1'b0;
      entries_d[head_q].complete = 1'b0;
      head_d                     = head_q + 1'b1;
    end

    if (alloc_fire) begin
      entries_d[tail_q] = '{pd_new:    alloc_pd_new,
                            pd_old:    alloc_pd_old,
                            pc:        alloc_pc,
                            complete:  1'b0,
                            rob_index: tail_q,
                            valid:     1'b1};
      tail_d            = tail_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

endmodule
